// File: rtl/mm_pkg.sv
// Shared constants and types for the modular-multiplication cluster:
// operand widths, the issue tag carried alongside the multiplier, and a clog2 helper.
package mm_pkg;

    localparam int MM_WIDTH   = 256;
    localparam int MM_PROD_W  = 2 * MM_WIDTH;
    localparam int MM_MAX_REQ = 8;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

    // Tag id is sized for the largest supported requester count.
    localparam int TAG_IDW = clog2(MM_MAX_REQ);

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/karatsuba_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, searching upward from a
// registered pointer that moves past the winner when update_en is set.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   eligible,
    input  logic           update_en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id
);

    logic [IDW-1:0] ptr;

    // Walk the offsets from farthest to nearest so the nearest eligible
    // index from the pointer is the last (winning) assignment.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant    = '0;
        grant_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (eligible[idx]) begin
                grant    = N'(1) << idx;
                grant_id = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (update_en && |grant) begin
            ptr <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/karatsuba_arbiter.sv
// Shares one pipelined karatsuba multiplier between NREQ requesters; a tag
// pipeline matched to MUL_LAT routes each product back to its issuer.
module karatsuba_arbiter
    import mm_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int WIDTH   = MM_WIDTH,
    parameter  int MUL_LAT = 6,
    parameter  int MAX_OUT = 4,
    localparam int IDW     = clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    input  logic                  hold,
    output logic                  mul_in_valid,
    output logic [WIDTH-1:0]      mul_x,
    output logic [WIDTH-1:0]      mul_y,
    input  logic [2*WIDTH-1:0]    mul_p,
    input  logic                  mul_out_valid,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_p,
    output logic [IDW-1:0]        rsp_id,
    output logic                  idle,
    output logic                  seq_error
);

    localparam int CNT_W = clog2(MAX_OUT + 1);

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic             handshake;
    logic [NREQ-1:0]  issue_hit;
    logic [NREQ-1:0]  retire_hit;
    logic [CNT_W-1:0] outstanding [NREQ];
    tag_t             tag_pipe    [MUL_LAT+1];
    tag_t             head;
    logic             tags_busy;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (outstanding[i] < CNT_W'(MAX_OUT)) && !hold && !reset;
        end
    end

    rr_arbiter #(.N(NREQ), .IDW(IDW)) u_rr (
        .clock     (clock),
        .reset     (reset),
        .eligible  (eligible),
        .update_en (handshake),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    assign req_ready = grant;
    assign handshake = |grant;

    // Stage k holds the tag issued k+1 cycles ago; the last stage lines up with mul_out_valid.
    assign head = tag_pipe[MUL_LAT];

    always_comb begin
        tags_busy  = 1'b0;
        retire_hit = '0;
        for (int k = 0; k <= MUL_LAT; k++) begin
            tags_busy = tags_busy | tag_pipe[k].valid;
        end
        for (int i = 0; i < NREQ; i++) begin
            retire_hit[i] = head.valid && (head.id == TAG_IDW'(i));
        end
    end

    assign issue_hit = grant;
    assign idle      = !tags_busy && !handshake;

    always_ff @(posedge clock) begin
        if (reset) begin
            mul_in_valid <= 1'b0;
            mul_x        <= '0;
            mul_y        <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            mul_in_valid <= handshake;
            if (handshake) begin
                mul_x <= req_x[grant_id*WIDTH +: WIDTH];
                mul_y <= req_y[grant_id*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the tag array is reset because its valid bits are control state, not data.
            for (int k = 0; k <= MUL_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: handshake, id: TAG_IDW'(grant_id)};
            for (int k = 1; k <= MUL_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_p     <= '0;
            rsp_id    <= '0;
            seq_error <= 1'b0;
        end else begin
            rsp_valid <= mul_out_valid ? retire_hit : '0;
            if (head.valid && mul_out_valid) begin
                rsp_p  <= mul_p;
                rsp_id <= head.id[IDW-1:0];
            end
            seq_error <= seq_error | (head.valid ^ mul_out_valid);
        end
    end

    // A retiring tag frees its slot even when the multiplier failed to deliver.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) outstanding[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({issue_hit[i], retire_hit[i]})
                    2'b10: if (outstanding[i] != CNT_W'(MAX_OUT)) outstanding[i] <= outstanding[i] + 1'b1;
                    2'b01: if (outstanding[i] != '0) outstanding[i] <= outstanding[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_karatsuba_arbiter.sv
// Randomized bench for karatsuba_arbiter: a behavioural karatsuba stand-in plus an
// expected-response queue model derived from grant order and fixed round-trip latency.
module tb_karatsuba_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 256;
    localparam int MUL_LAT = 6;
    localparam int MAX_OUT = 4;
    localparam int IDW     = 2;
    localparam int PW      = 2 * WIDTH;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  hold = 1'b0;
    logic                  inject = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_x = '0;
    logic [NREQ*WIDTH-1:0] req_y = '0;
    logic                  mul_in_valid;
    logic [WIDTH-1:0]      mul_x;
    logic [WIDTH-1:0]      mul_y;
    logic [PW-1:0]         mul_p;
    logic                  mul_out_valid;
    logic [NREQ-1:0]       rsp_valid;
    logic [PW-1:0]         rsp_p;
    logic [IDW-1:0]        rsp_id;
    logic                  idle;
    logic                  seq_error;

    always #5 clock = ~clock;

    karatsuba_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .MAX_OUT(MAX_OUT)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .hold          (hold),
        .mul_in_valid  (mul_in_valid),
        .mul_x         (mul_x),
        .mul_y         (mul_y),
        .mul_p         (mul_p),
        .mul_out_valid (mul_out_valid),
        .rsp_valid     (rsp_valid),
        .rsp_p         (rsp_p),
        .rsp_id        (rsp_id),
        .idle          (idle),
        .seq_error     (seq_error)
    );

    // Behavioural multiplier: out_valid exactly MUL_LAT cycles after in_valid.
    logic          kv [MUL_LAT];
    logic [PW-1:0] kp [MUL_LAT];

    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < MUL_LAT; k++) kv[k] <= 1'b0;
        end else begin
            kv[0] <= mul_in_valid;
            kp[0] <= PW'(mul_x) * PW'(mul_y);
            for (int k = 1; k < MUL_LAT; k++) begin
                kv[k] <= kv[k-1];
                kp[k] <= kp[k-1];
            end
        end
    end

    assign mul_out_valid = kv[MUL_LAT-1] | inject;
    assign mul_p         = kp[MUL_LAT-1];

    typedef struct {
        int            id;
        logic [PW-1:0] p;
        int            due;
    } exp_t;

    exp_t             q[$];
    int               cyc = 0;
    int               m_ptr = 0;
    bit               m_issue = 1'b0;
    bit               m_seq = 1'b0;
    logic [WIDTH-1:0] m_x;
    logic [WIDTH-1:0] m_y;
    int               n_checks = 0;
    int               n_fail = 0;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Operations still holding a slot: issued, response not yet due.
    function automatic int in_flight(input int id, input int c);
        int n;
        n = 0;
        foreach (q[j]) if (q[j].id == id && q[j].due > c) n++;
        return n;
    endfunction

    task automatic set_op(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        req_x[i*WIDTH +: WIDTH] = x;
        req_y[i*WIDTH +: WIDTH] = y;
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        logic [WIDTH-1:0] v;
        for (int w = 0; w < WIDTH / 32; w++) v[w*32 +: 32] = $urandom;
        if ($urandom_range(0, 9) == 0) v = '1;
        return v;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op());
    endtask

    // One clock: check all outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        int               exp_g;
        logic [NREQ-1:0]  exp_ready;
        bit               busy;
        bit               head_now;
        logic [WIDTH-1:0] gx;
        logic [WIDTH-1:0] gy;
        exp_t             e;
        @(negedge clock);
        exp_g = -1;
        if (!reset && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (exp_g < 0 && req_valid[i] && in_flight(i, cyc) < MAX_OUT) exp_g = i;
            end
        end
        exp_ready = (exp_g >= 0) ? (NREQ'(1) << exp_g) : '0;
        check("req_ready", PW'(req_ready), PW'(exp_ready));
        check("mul_in_valid", PW'(mul_in_valid), PW'(m_issue));
        if (m_issue) begin
            check("mul_x", PW'(mul_x), PW'(m_x));
            check("mul_y", PW'(mul_y), PW'(m_y));
        end
        busy     = (exp_g >= 0);
        head_now = 1'b0;
        foreach (q[j]) begin
            if (q[j].due > cyc) busy = 1'b1;
            if (q[j].due == cyc + 1) head_now = 1'b1;
        end
        check("idle", PW'(idle), PW'(!busy));
        check("seq_error", PW'(seq_error), PW'(m_seq));
        if (q.size() > 0 && q[0].due == cyc) begin
            check("rsp_valid", PW'(rsp_valid), PW'(NREQ'(1) << q[0].id));
            check("rsp_id", PW'(rsp_id), PW'(q[0].id));
            check("rsp_p", rsp_p, q[0].p);
            void'(q.pop_front());
        end else begin
            check("rsp_valid_quiet", PW'(rsp_valid), '0);
        end
        if (exp_g >= 0) begin
            gx = req_x[exp_g*WIDTH +: WIDTH];
            gy = req_y[exp_g*WIDTH +: WIDTH];
        end
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_ptr   = 0;
            m_issue = 1'b0;
            m_seq   = 1'b0;
        end else begin
            m_issue = (exp_g >= 0);
            if (m_issue) begin
                m_x   = gx;
                m_y   = gy;
                e.id  = exp_g;
                e.p   = PW'(gx) * PW'(gy);
                e.due = cyc + MUL_LAT + 2;
                q.push_back(e);
                m_ptr = (exp_g + 1) % NREQ;
            end
            if (inject && !head_now) m_seq = 1'b1;
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PW-1:0] max_sq;

        req_valid = '1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_req_ready", PW'(req_ready), '0);
        check("reset_mul_in_valid", PW'(mul_in_valid), '0);
        check("reset_mul_x", PW'(mul_x), '0);
        check("reset_mul_y", PW'(mul_y), '0);
        check("reset_rsp_valid", PW'(rsp_valid), '0);
        check("reset_rsp_p", rsp_p, '0);
        check("reset_rsp_id", PW'(rsp_id), '0);
        check("reset_seq_error", PW'(seq_error), '0);
        check("reset_idle", PW'(idle), PW'(1));
        tick();
        reset     = 1'b0;
        req_valid = '0;

        // Single operation from requester 2.
        set_op(2, 3, 5);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        run(12);
        check("single_rsp_p", rsp_p, PW'(15));
        check("single_idle", PW'(idle), PW'(1));

        // All requesters streaming.
        req_valid = '1;
        repeat (40) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        run(12);

        // One requester alone runs into its outstanding limit.
        req_valid = 4'b1000;
        repeat (20) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        run(12);

        // Largest operands.
        set_op(0, '1, '1);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        run(12);
        max_sq = '0;
        max_sq = max_sq - (PW'(1) << (WIDTH + 1)) + PW'(1);
        check("max_rsp_p", rsp_p, max_sq);

        // Random request patterns with occasional hold.
        repeat (300) begin
            rand_ops();
            req_valid = NREQ'($urandom);
            hold      = ($urandom_range(0, 5) == 0);
            tick();
        end
        hold      = 1'b0;
        req_valid = '0;
        run(12);

        // Hold with three operations in flight.
        req_valid = '1;
        repeat (3) begin
            rand_ops();
            tick();
        end
        hold = 1'b1;
        run(12);
        check("hold_idle", PW'(idle), PW'(1));
        check("hold_ready", PW'(req_ready), '0);
        hold      = 1'b0;
        req_valid = '0;
        tick();

        // Spurious out_valid with an empty pipeline.
        inject = 1'b1;
        tick();
        inject = 1'b0;
        run(3);
        check("seq_error_sticky", PW'(seq_error), PW'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("seq_error_cleared", PW'(seq_error), '0);

        // Reset two cycles after an issue discards that operation.
        set_op(1, 7, 9);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(12);
        check("reset_drop_idle", PW'(idle), PW'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
